rob_retire_ctrl: RTL and testbench

ROB_RETIRE_CTRL -- requirements
Module: rob_retire_ctrl

---
 rtl/rob_retire_ctrl.sv | 129 ++++++++++++
 tb/tb_rob_retire_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire_ctrl.sv
// rob_retire_ctrl: in-order retirement control at the ROB head.
// Retires up to RETIRE_RATE completed entries per cycle (at most one store),
// and sequences a precise exception: drain store buffer, flush, then hold a
// trap redirect until the front end acknowledges it.
module rob_retire_ctrl #(
    parameter int RETIRE_RATE = 2,
    parameter int ROB_DEPTH   = 64,
    parameter int ECAUSE_W    = 5,
    parameter int PC_W        = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [RETIRE_RATE-1:0]          head_valid,
    input  logic [RETIRE_RATE-1:0]          head_busy,
    input  logic [RETIRE_RATE-1:0]          head_exc,
    input  logic [RETIRE_RATE*ECAUSE_W-1:0] head_ecause,
    input  logic [RETIRE_RATE*PC_W-1:0]     head_pc,
    input  logic [RETIRE_RATE-1:0]          head_store,
    input  logic [$clog2(ROB_DEPTH):0]      used_entries,
    input  logic                            st_commit_rdy,
    input  logic                            sb_empty,
    input  logic                            trap_ack,
    output logic [$clog2(RETIRE_RATE):0]    retire_cnt,
    output logic                            st_commit_valid,
    output logic                            flush,
    output logic                            trap_valid,
    output logic [ECAUSE_W-1:0]             trap_cause,
    output logic [PC_W-1:0]                 trap_pc,
    output logic [63:0]                     instret
);

    localparam int USED_W = $clog2(ROB_DEPTH) + 1;
    localparam int CNT_W  = $clog2(RETIRE_RATE) + 1;

    typedef enum logic [1:0] {RUN, DRAIN, FLUSH, TRAP} state_e;

    state_e              state_q, state_d;
    logic                flush_q;
    logic                trap_valid_q;
    logic [ECAUSE_W-1:0] trap_cause_q;
    logic [PC_W-1:0]     trap_pc_q;
    logic [63:0]         instret_q;

    logic                take_exc;
    logic                slot_ok;
    logic                stop;

    // Cause/PC of younger slots never reach the trap registers; an excepting
    // younger entry is only handled once it becomes the head.
    generate
        if (RETIRE_RATE > 1) begin : g_unused
            logic unused_upper_slots;
            assign unused_upper_slots = ^{head_ecause[RETIRE_RATE*ECAUSE_W-1:ECAUSE_W],
                                          head_pc[RETIRE_RATE*PC_W-1:PC_W]};
        end
    endgenerate

    // Exception is taken only when the head entry itself has completed with a fault.
    assign take_exc = (state_q == RUN) && (used_entries != '0) && head_valid[0]
                      && !head_busy[0] && head_exc[0];

    // Walk head slots in order; the first slot that cannot retire stops the walk.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        retire_cnt      = '0;
        st_commit_valid = 1'b0;
        slot_ok         = 1'b0;
        stop            = 1'b0;
        if (!rst && state_q == RUN) begin
            for (int i = 0; i < RETIRE_RATE; i++) begin
                slot_ok = (USED_W'(i) < used_entries) && head_valid[i]
                          && !head_busy[i] && !head_exc[i];
                // Only one store port into the store buffer per cycle.
                if (head_store[i]) begin
                    slot_ok = slot_ok && st_commit_rdy && !st_commit_valid;
                end
                if (!stop && slot_ok) begin
                    retire_cnt = retire_cnt + CNT_W'(1);
                    if (head_store[i]) begin
                        st_commit_valid = 1'b1;
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

    // Exception sequencing: RUN -> DRAIN -> FLUSH -> TRAP -> RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (take_exc) state_d = DRAIN;
            DRAIN:   if (sb_empty) state_d = FLUSH;
            FLUSH:   state_d = TRAP;
            TRAP:    if (trap_ack) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // State, registered flush/trap outputs, trap capture and retired counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q      <= RUN;
            flush_q      <= 1'b0;
            trap_valid_q <= 1'b0;
            trap_cause_q <= '0;
            trap_pc_q    <= '0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            flush_q      <= (state_d == FLUSH);
            trap_valid_q <= (state_d == TRAP);
            if (take_exc) begin
                trap_cause_q <= head_ecause[ECAUSE_W-1:0];
                trap_pc_q    <= head_pc[PC_W-1:0];
            end
            instret_q    <= instret_q + 64'(retire_cnt);
        end
    end

    assign flush      = flush_q;
    assign trap_valid = trap_valid_q;
    assign trap_cause = trap_cause_q;
    assign trap_pc    = trap_pc_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Scoreboard bench for rob_retire_ctrl: a driver applies one stimulus per cycle
// and pushes the reference model's expected outputs; a monitor pops and compares.
module tb_rob_retire_ctrl;

    localparam int RR = 2;
    localparam int EW = 5;
    localparam int PW = 64;

    typedef struct {
        logic           rst;
        int             used;
        logic [RR-1:0]  valid;
        logic [RR-1:0]  busy;
        logic [RR-1:0]  exc;
        logic [RR-1:0]  store;
        logic           st_rdy;
        logic           sb_empty;
        logic           ack;
        logic [RR*EW-1:0] ecause;
        logic [RR*PW-1:0] pc;
    } stim_t;

    typedef struct {
        int          cyc;
        int          cnt;
        bit          stc;
        bit          fl;
        bit          tv;
        logic [EW-1:0] cause;
        logic [PW-1:0] pc;
        logic [63:0] instret;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [RR-1:0]     head_valid, head_busy, head_exc, head_store;
    logic [RR*EW-1:0]  head_ecause;
    logic [RR*PW-1:0]  head_pc;
    logic [6:0]        used_entries;
    logic              st_commit_rdy, sb_empty, trap_ack;
    logic [1:0]        retire_cnt;
    logic              st_commit_valid, flush, trap_valid;
    logic [EW-1:0]     trap_cause;
    logic [PW-1:0]     trap_pc;
    logic [63:0]       instret;

    rob_retire_ctrl #(.RETIRE_RATE(RR), .ROB_DEPTH(64), .ECAUSE_W(EW), .PC_W(PW)) dut (
        .clk(clk), .rst(rst),
        .head_valid(head_valid), .head_busy(head_busy), .head_exc(head_exc),
        .head_ecause(head_ecause), .head_pc(head_pc), .head_store(head_store),
        .used_entries(used_entries), .st_commit_rdy(st_commit_rdy),
        .sb_empty(sb_empty), .trap_ack(trap_ack),
        .retire_cnt(retire_cnt), .st_commit_valid(st_commit_valid),
        .flush(flush), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .instret(instret)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;
    exp_t exp_q[$];

    // Reference model state: what the controller is doing, as plain flags.
    bit            m_draining = 0;
    bit            m_flushing = 0;
    bit            m_trapping = 0;
    logic [EW-1:0] m_cause    = '0;
    logic [PW-1:0] m_pc       = '0;
    logic [63:0]   m_instret  = '0;

    task automatic check(input string name, input int cyc, input logic [63:0] act,
                         input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    function automatic stim_t base_stim();
        stim_t s;
        s.rst = 1'b0; s.used = 5; s.valid = '1; s.busy = '0; s.exc = '0; s.store = '0;
        s.st_rdy = 1'b1; s.sb_empty = 1'b1; s.ack = 1'b0;
        s.ecause = '0;
        s.pc = {64'h1004, 64'h1000};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst = ($urandom_range(0, 79) == 0);
        s.used = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 64) : $urandom_range(0, 3);
        for (int i = 0; i < RR; i++) begin
            s.valid[i] = ($urandom_range(0, 7) != 0);
            s.busy[i]  = ($urandom_range(0, 3) == 0);
            s.exc[i]   = ($urandom_range(0, 11) == 0);
            s.store[i] = ($urandom_range(0, 2) == 0);
        end
        s.st_rdy   = ($urandom_range(0, 3) != 0);
        s.sb_empty = ($urandom_range(0, 1) == 0);
        s.ack      = ($urandom_range(0, 2) == 0);
        s.ecause   = RR*EW'($urandom);
        s.pc       = {$urandom, $urandom, $urandom, $urandom};
        return s;
    endfunction

    // Drive one cycle of stimulus, predict this cycle's outputs, then advance the model.
    task automatic apply(input stim_t s);
        exp_t e;
        bit   running;
        int   n;
        int   cnt;
        bit   stc;
        bit   exc0;
        @(posedge clk);
        #1;
        rst = s.rst; used_entries = 7'(s.used);
        head_valid = s.valid; head_busy = s.busy; head_exc = s.exc; head_store = s.store;
        st_commit_rdy = s.st_rdy; sb_empty = s.sb_empty; trap_ack = s.ack;
        head_ecause = s.ecause; head_pc = s.pc;

        running = !m_draining && !m_flushing && !m_trapping;
        cnt = 0;
        stc = 0;
        if (!s.rst && running) begin
            n = (s.used < RR) ? s.used : RR;
            for (int i = 0; i < n; i++) begin
                if (!s.valid[i] || s.busy[i] || s.exc[i]) break;
                if (s.store[i]) begin
                    if (!s.st_rdy || stc) break;
                    stc = 1;
                end
                cnt++;
            end
        end
        e.cyc = cycle; e.cnt = cnt; e.stc = stc; e.fl = m_flushing; e.tv = m_trapping;
        e.cause = m_cause; e.pc = m_pc; e.instret = m_instret;
        exp_q.push_back(e);
        cycle++;

        exc0 = running && (s.used >= 1) && s.valid[0] && !s.busy[0] && s.exc[0];
        if (s.rst) begin
            m_draining = 0; m_flushing = 0; m_trapping = 0;
            m_cause = '0; m_pc = '0; m_instret = '0;
        end else begin
            m_instret = m_instret + 64'(cnt);
            if (exc0) begin
                m_draining = 1;
                m_cause = s.ecause[EW-1:0];
                m_pc = s.pc[PW-1:0];
            end else if (m_draining) begin
                if (s.sb_empty) begin
                    m_draining = 0;
                    m_flushing = 1;
                end
            end else if (m_flushing) begin
                m_flushing = 0;
                m_trapping = 1;
            end else if (m_trapping && s.ack) begin
                m_trapping = 0;
            end
        end
    endtask

    // Monitor: compare the DUT against the oldest prediction mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("retire_cnt", e.cyc, 64'(retire_cnt), 64'(e.cnt));
                check("st_commit_valid", e.cyc, 64'(st_commit_valid), 64'(e.stc));
                check("flush", e.cyc, 64'(flush), 64'(e.fl));
                check("trap_valid", e.cyc, 64'(trap_valid), 64'(e.tv));
                check("trap_cause", e.cyc, 64'(trap_cause), 64'(e.cause));
                check("trap_pc", e.cyc, trap_pc, e.pc);
                check("instret", e.cyc, instret, e.instret);
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1; used_entries = '0; head_valid = '0; head_busy = '0; head_exc = '0;
        head_store = '0; st_commit_rdy = 1'b0; sb_empty = 1'b1; trap_ack = 1'b0;
        head_ecause = '0; head_pc = '0;
        repeat (2) @(posedge clk);

        // Reset held with ready entries present: nothing may retire.
        s = base_stim(); s.rst = 1'b1;
        apply(s);

        // Full-rate retirement of plain instructions.
        s = base_stim();
        repeat (4) apply(s);

        // Busy head blocks everything; a single occupied entry caps the count.
        s = base_stim(); s.busy = 2'b01;
        apply(s);
        s = base_stim(); s.used = 1;
        apply(s);
        s = base_stim(); s.used = 0;
        apply(s);

        // Two stores: one per cycle, none when the store buffer is not ready.
        s = base_stim(); s.store = 2'b11;
        apply(s);
        s.st_rdy = 1'b0;
        apply(s);

        // Younger slot faults: head retires, then the fault reaches slot 0.
        s = base_stim(); s.exc = 2'b10; s.ecause = {5'd5, 5'd0};
        apply(s);
        s = base_stim(); s.exc = 2'b01; s.ecause = {5'd0, 5'd5};
        s.pc = {64'h1008, 64'h1004}; s.sb_empty = 1'b0;
        apply(s);
        s = base_stim(); s.sb_empty = 1'b0; s.ack = 1'b1;
        repeat (3) apply(s);
        s.sb_empty = 1'b1; s.ack = 1'b0;
        repeat (5) apply(s);
        s.ack = 1'b1;
        apply(s);
        s.ack = 1'b0;
        repeat (2) apply(s);

        // Enter TRAP again, then abort it with reset.
        s = base_stim(); s.exc = 2'b01; s.ecause = {5'd0, 5'd9};
        apply(s);
        s = base_stim();
        repeat (4) apply(s);
        s.rst = 1'b1;
        apply(s);
        s.rst = 1'b0;
        repeat (3) apply(s);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            apply(rand_stim());
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
